// File: rtl/xgmii_rx_checker.sv
// Receive-side XGMII frame checker. Parses /S/ ... /T/ framing, checks the preamble/SFD,
// the frame length and the Ethernet FCS, and keeps per-port frame statistics.
module xgmii_rx_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk156,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        rx_active,
    output logic        frame_done,
    output logic        frame_good,
    output logic [15:0] frame_len,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_crc_err,
    output logic [31:0] cnt_len_err,
    output logic [31:0] cnt_fmt_err
);
    localparam logic [7:0]  CH_IDLE      = 8'h07;
    localparam logic [7:0]  CH_START     = 8'hFB;
    localparam logic [7:0]  CH_TERM      = 8'hFD;
    localparam logic [55:0] PREAMBLE     = 56'hD5_5555_5555_5555;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam logic [15:0] MIN_L        = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L        = 16'(MAX_LEN);

    typedef enum logic {IDLE, DATA} state_t;

    // LSB-first CRC-32 over the lowest nbytes lanes of one word.
    function automatic logic [31:0] crc_bytes(input logic [31:0] crc_in, input logic [63:0] data,
                                              input logic [3:0] nbytes);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                for (int b = 0; b < 8; b++) begin
                    if (c[0] ^ data[8*i+b]) c = (c >> 1) ^ CRC_POLY_REF;
                    else                    c = c >> 1;
                end
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] len_add(input logic [15:0] len, input logic [3:0] n);
        logic [16:0] sum;
        sum = {1'b0, len} + {13'd0, n};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Stage 1: registered XGMII word
    logic [63:0] rxd_q, rxd_d;
    logic [7:0]  rxc_q, rxc_d;

    // Stage 2: frame parser and running CRC/length
    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic        fmt_q, fmt_d;

    // Completed frame waiting for classification
    logic        pend_vld_q, pend_vld_d;
    logic        pend_fmt_q, pend_fmt_d;
    logic [15:0] pend_len_q, pend_len_d;
    logic [31:0] pend_crc_q, pend_crc_d;

    // Stage 3: results and statistics
    logic        frame_done_q, frame_done_d;
    logic        frame_good_q, frame_good_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [31:0] cnt_good_q, cnt_good_d;
    logic [31:0] cnt_crc_q, cnt_crc_d;
    logic [31:0] cnt_len_q, cnt_len_d;
    logic [31:0] cnt_fmt_q, cnt_fmt_d;

    // Word decode
    logic       s_word, pre_ok, term_hit, term_bad;
    logic [2:0] term_k;

    always_comb begin
        s_word   = (rxc_q == 8'h01) && (rxd_q[7:0] == CH_START);
        pre_ok   = (rxd_q[63:8] == PREAMBLE);
        term_hit = 1'b0;
        term_k   = 3'd0;
        // Descending scan leaves the lowest /T/ lane selected.
        for (int k = 7; k >= 0; k--) begin
            if (rxc_q[k] && (rxd_q[8*k +: 8] == CH_TERM)) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
        term_bad = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) < term_k) && rxc_q[j]) term_bad = 1'b1;
            if ((3'(j) > term_k) && (!rxc_q[j] || (rxd_q[8*j +: 8] != CH_IDLE))) term_bad = 1'b1;
        end
    end

    always_comb begin
        rxd_d        = xgmii_rxd;
        rxc_d        = xgmii_rxc;
        state_d      = state_q;
        len_d        = len_q;
        crc_d        = crc_q;
        fmt_d        = fmt_q;
        pend_vld_d   = 1'b0;
        pend_fmt_d   = pend_fmt_q;
        pend_len_d   = pend_len_q;
        pend_crc_d   = pend_crc_q;
        frame_done_d = 1'b0;
        frame_good_d = 1'b0;
        frame_len_d  = frame_len_q;
        cnt_good_d   = cnt_good_q;
        cnt_crc_d    = cnt_crc_q;
        cnt_len_d    = cnt_len_q;
        cnt_fmt_d    = cnt_fmt_q;

        case (state_q)
            IDLE: begin
                if (s_word) begin
                    state_d = DATA;
                    len_d   = 16'd0;
                    crc_d   = CRC_INIT;
                    fmt_d   = !pre_ok;
                end
            end
            DATA: begin
                if (rxc_q == 8'h00) begin
                    len_d = len_add(len_q, 4'd8);
                    crc_d = crc_bytes(crc_q, rxd_q, 4'd8);
                end else if (s_word) begin
                    // Restart without /T/: close the old frame as malformed.
                    pend_vld_d = 1'b1;
                    pend_fmt_d = 1'b1;
                    pend_len_d = len_q;
                    pend_crc_d = crc_q;
                    len_d      = 16'd0;
                    crc_d      = CRC_INIT;
                    fmt_d      = !pre_ok;
                end else if (term_hit) begin
                    pend_vld_d = 1'b1;
                    pend_fmt_d = fmt_q | term_bad;
                    pend_len_d = len_add(len_q, {1'b0, term_k});
                    pend_crc_d = crc_bytes(crc_q, rxd_q, {1'b0, term_k});
                    state_d    = IDLE;
                end else begin
                    fmt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pend_vld_q) begin
            frame_done_d = 1'b1;
            frame_len_d  = pend_len_q;
            if (pend_fmt_q)                                   cnt_fmt_d = cnt_fmt_q + 32'd1;
            else if ((pend_len_q < MIN_L) || (pend_len_q > MAX_L)) cnt_len_d = cnt_len_q + 32'd1;
            else if (bit_rev(pend_crc_q) != CRC_RESIDUE)      cnt_crc_d = cnt_crc_q + 32'd1;
            else begin
                cnt_good_d   = cnt_good_q + 32'd1;
                frame_good_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            rxd_q        <= 64'd0;
            rxc_q        <= 8'd0;
            state_q      <= IDLE;
            len_q        <= 16'd0;
            crc_q        <= CRC_INIT;
            fmt_q        <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_fmt_q   <= 1'b0;
            pend_len_q   <= 16'd0;
            pend_crc_q   <= 32'd0;
            frame_done_q <= 1'b0;
            frame_good_q <= 1'b0;
            frame_len_q  <= 16'd0;
            cnt_good_q   <= 32'd0;
            cnt_crc_q    <= 32'd0;
            cnt_len_q    <= 32'd0;
            cnt_fmt_q    <= 32'd0;
        end else begin
            rxd_q        <= rxd_d;
            rxc_q        <= rxc_d;
            state_q      <= state_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            fmt_q        <= fmt_d;
            pend_vld_q   <= pend_vld_d;
            pend_fmt_q   <= pend_fmt_d;
            pend_len_q   <= pend_len_d;
            pend_crc_q   <= pend_crc_d;
            frame_done_q <= frame_done_d;
            frame_good_q <= frame_good_d;
            frame_len_q  <= frame_len_d;
            cnt_good_q   <= cnt_good_d;
            cnt_crc_q    <= cnt_crc_d;
            cnt_len_q    <= cnt_len_d;
            cnt_fmt_q    <= cnt_fmt_d;
        end
    end

    assign rx_active   = (state_q == DATA);
    assign frame_done  = frame_done_q;
    assign frame_good  = frame_good_q;
    assign frame_len   = frame_len_q;
    assign cnt_good    = cnt_good_q;
    assign cnt_crc_err = cnt_crc_q;
    assign cnt_len_err = cnt_len_q;
    assign cnt_fmt_err = cnt_fmt_q;

endmodule

// File: tb/tb_xgmii_rx_checker.sv
// Bench for xgmii_rx_checker: table of frames driven through a word builder, with results
// checked by a scoreboard against frame_done, plus hand sequences for reset and restart.
module tb_xgmii_rx_checker;
    logic        clk156 = 1'b0;
    logic        sys_rst = 1'b1;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_active, frame_done, frame_good;
    logic [15:0] frame_len;
    logic [31:0] cnt_good, cnt_crc_err, cnt_len_err, cnt_fmt_err;

    localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] BADSF_W = 64'h5555_5555_5555_55FB;

    always #5 clk156 = ~clk156;

    xgmii_rx_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk156(clk156), .sys_rst(sys_rst), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .rx_active(rx_active), .frame_done(frame_done), .frame_good(frame_good),
        .frame_len(frame_len), .cnt_good(cnt_good), .cnt_crc_err(cnt_crc_err),
        .cnt_len_err(cnt_len_err), .cnt_fmt_err(cnt_fmt_err)
    );

    // cls: 0 good, 1 crc, 2 len, 3 fmt; len -1 = not checked
    typedef struct { int cls; int len; int cyc; } exp_t;
    typedef struct { int len; int mode; int gap; int cls; int elen; } vec_t;

    exp_t        sb[$];
    logic [63:0] wd[$];
    logic [7:0]  wc[$];
    int checks = 0, failures = 0, cyc = 0;
    int m_good = 0, m_crc = 0, m_len = 0, m_fmt = 0;

    always @(posedge clk156) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk156) begin : mon
        exp_t e;
        if (!sys_rst && frame_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: frame_done=1 with no frame outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("frame_good", frame_good, e.cls == 0);
                if (e.len >= 0) chk("frame_len", frame_len, e.len);
                chk("done_cycle", cyc, e.cyc);
                case (e.cls)
                    0: m_good++;
                    1: m_crc++;
                    2: m_len++;
                    default: m_fmt++;
                endcase
                chk("cnt_good", cnt_good, m_good);
                chk("cnt_crc_err", cnt_crc_err, m_crc);
                chk("cnt_len_err", cnt_len_err, m_len);
                chk("cnt_fmt_err", cnt_fmt_err, m_fmt);
            end
        end
    end

    // mode: 0 good, 1 payload bit flip, 2 /E/ in lane 3 of data word 3, 3 bad SFD
    task automatic build(input int len, input int mode);
        logic [7:0]  by[$];
        logic [31:0] c;
        logic [63:0] w;
        logic [7:0]  cw;
        int nw, r;
        wd.delete();
        wc.delete();
        for (int i = 0; i < len - 4; i++) by.push_back(8'($urandom_range(0, 255)));
        c = 32'hFFFF_FFFF;
        foreach (by[i]) begin
            c ^= {24'd0, by[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) by.push_back(c[8*i +: 8]);
        if (mode == 1) by[20] = by[20] ^ 8'h08;
        wd.push_back(mode == 3 ? BADSF_W : START_W);
        wc.push_back(8'h01);
        nw = len / 8;
        r  = len % 8;
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = by[8*i+b];
            cw = 8'h00;
            if (mode == 2 && i == 3) begin
                w[31:24] = 8'hFE;
                cw       = 8'h08;
            end
            wd.push_back(w);
            wc.push_back(cw);
        end
        w  = IDLE_W;
        cw = 8'hFF;
        for (int b = 0; b < r; b++) begin
            w[8*b +: 8] = by[8*nw+b];
            cw[b]       = 1'b0;
        end
        w[8*r +: 8] = 8'hFD;
        wd.push_back(w);
        wc.push_back(cw);
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        @(posedge clk156);
        #1;
        xgmii_rxd = d;
        xgmii_rxc = c;
    endtask

    // Called right after driving the word that closes a frame.
    task automatic push_exp(input int cls, input int len);
        exp_t e;
        e.cls = cls;
        e.len = len;
        e.cyc = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic send_frame(input int len, input int mode, input int gap, input int cls, input int elen);
        build(len, mode);
        foreach (wd[i]) drive(wd[i], wc[i]);
        push_exp(cls, elen);
        repeat (gap) drive(IDLE_W, 8'hFF);
    endtask

    vec_t vecs[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   t;
        xgmii_rxd = IDLE_W;
        xgmii_rxc = 8'hFF;
        repeat (3) @(posedge clk156);
        #1;
        chk("rst_rx_active", rx_active, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_good", frame_good, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_cnt_good", cnt_good, 0);
        chk("rst_cnt_crc", cnt_crc_err, 0);
        chk("rst_cnt_len", cnt_len_err, 0);
        chk("rst_cnt_fmt", cnt_fmt_err, 0);
        sys_rst = 1'b0;
        repeat (2) drive(IDLE_W, 8'hFF);

        // Reset on data word 4; the remainder of the frame must be ignored.
        build(64, 0);
        for (int i = 0; i <= 4; i++) drive(wd[i], wc[i]);
        sys_rst = 1'b1;
        drive(wd[5], wc[5]);
        sys_rst = 1'b0;
        for (int i = 6; i < wd.size(); i++) drive(wd[i], wc[i]);
        repeat (5) drive(IDLE_W, 8'hFF);
        chk("rstmid_cnt_good", cnt_good, 0);
        chk("rstmid_cnt_crc", cnt_crc_err, 0);
        chk("rstmid_cnt_len", cnt_len_err, 0);
        chk("rstmid_cnt_fmt", cnt_fmt_err, 0);
        chk("rstmid_rx_active", rx_active, 0);
        send_frame(64, 0, 4, 0, 64);
        chk("rstmid_then_good", cnt_good, 1);

        for (int i = 0; i < 10; i++) begin v = '{64, 0, 1, 0, 64}; vecs.push_back(v); end
        v = '{64, 0, 0, 0, 64};      vecs.push_back(v);
        v = '{72, 0, 1, 0, 72};      vecs.push_back(v);
        for (int k = 0; k < 8; k++) begin v = '{64 + k, 0, 1, 0, 64 + k}; vecs.push_back(v); end
        v = '{100, 1, 1, 1, 100};    vecs.push_back(v);
        v = '{60, 0, 1, 2, 60};      vecs.push_back(v);
        v = '{1519, 0, 1, 2, 1519};  vecs.push_back(v);
        v = '{1518, 0, 1, 0, 1518};  vecs.push_back(v);
        v = '{64, 2, 1, 3, -1};      vecs.push_back(v);
        v = '{64, 3, 1, 3, 64};      vecs.push_back(v);
        foreach (vecs[i]) send_frame(vecs[i].len, vecs[i].mode, vecs[i].gap, vecs[i].cls, vecs[i].elen);

        // Second /S/ before /T/: 24-byte fragment closes as fmt, new frame is good.
        repeat (2) drive(IDLE_W, 8'hFF);
        drive(START_W, 8'h01);
        drive(64'h0102_0304_0506_0708, 8'h00);
        chk("rx_active_pre", rx_active, 0);
        drive(64'h1112_1314_1516_1718, 8'h00);
        chk("rx_active_rise", rx_active, 1);
        drive(64'h2122_2324_2526_2728, 8'h00);
        build(64, 0);
        drive(wd[0], wc[0]);
        push_exp(3, 24);
        for (int i = 1; i < wd.size(); i++) drive(wd[i], wc[i]);
        push_exp(0, 64);
        repeat (3) drive(IDLE_W, 8'hFF);
        chk("rx_active_fall", rx_active, 0);

        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(posedge clk156);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        #1;
        chk("final_cnt_good", cnt_good, 23);
        chk("final_cnt_crc", cnt_crc_err, 1);
        chk("final_cnt_len", cnt_len_err, 2);
        chk("final_cnt_fmt", cnt_fmt_err, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
